// File: rtl/axi_txn_limiter.sv
// Outstanding-transaction limiter for one crossbar master port: counts in-flight
// AXI writes and reads and stalls AW/AR issue once a runtime limit is reached.

package axi_txn_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [5:0]  atop;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;
endpackage

module axi_txn_limiter #(
  parameter int unsigned MaxTxns   = 8,
  parameter type         axi_req_t = axi_txn_pkg::axi_req_t,
  parameter type         axi_rsp_t = axi_txn_pkg::axi_rsp_t,
  localparam int unsigned CntW     = $clog2(MaxTxns + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  axi_req_t        slv_req_i,
  output axi_rsp_t        slv_resp_o,
  output axi_req_t        mst_req_o,
  input  axi_rsp_t        mst_resp_i,
  input  logic [CntW-1:0] max_w_txns_i,
  input  logic [CntW-1:0] max_r_txns_i,
  output logic [CntW-1:0] w_outstanding_o,
  output logic [CntW-1:0] r_outstanding_o,
  output logic            idle_o
);

  typedef logic [CntW:0] sum_t;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

  logic [CntW-1:0] w_cnt, r_cnt, w_cnt_d, r_cnt_d;
  logic [CntW-1:0] lw, lr;
  logic            aw_lock_q, ar_lock_q, aw_lock_d, ar_lock_d;
  logic            atop_r, aw_allow, ar_allow, aw_atop_pend;
  logic            aw_hs, ar_hs, b_hs, r_last_hs;

  assign lw     = (max_w_txns_i > MaxCnt) ? MaxCnt : max_w_txns_i;
  assign lr     = (max_r_txns_i > MaxCnt) ? MaxCnt : max_r_txns_i;
  assign atop_r = slv_req_i.aw.atop[5];

  // Sums are one bit wider so count + pending cannot wrap at the limit.
  assign aw_allow = aw_lock_q | ((w_cnt < lw) &
                    (~atop_r | ((sum_t'(r_cnt) + sum_t'(ar_lock_q)) < sum_t'(lr))));
  // An atomic returning R data claims the last read slot ahead of a plain AR.
  assign aw_atop_pend = slv_req_i.aw_valid & aw_allow & atop_r;
  assign ar_allow     = ar_lock_q | ((sum_t'(r_cnt) + sum_t'(aw_atop_pend)) < sum_t'(lr));

  always_comb begin
    // NOTE: every combinational output gets a full default first, so no path can infer a latch.
    mst_req_o           = slv_req_i;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_allow;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_allow;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow;
  end

  assign aw_hs     = slv_req_i.aw_valid & aw_allow & mst_resp_i.aw_ready;
  assign ar_hs     = slv_req_i.ar_valid & ar_allow & mst_resp_i.ar_ready;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

  always_comb begin
    w_cnt_d   = w_cnt + CntW'(aw_hs) - CntW'(b_hs);
    r_cnt_d   = r_cnt + CntW'(ar_hs) + CntW'(aw_hs & atop_r) - CntW'(r_last_hs);
    aw_lock_d = aw_lock_q;
    ar_lock_d = ar_lock_q;
    // A request shown downstream but not yet taken stays allowed until accepted.
    if (aw_hs)                               aw_lock_d = 1'b0;
    else if (slv_req_i.aw_valid & aw_allow)  aw_lock_d = 1'b1;
    if (ar_hs)                               ar_lock_d = 1'b0;
    else if (slv_req_i.ar_valid & ar_allow)  ar_lock_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_cnt     <= '0;
      r_cnt     <= '0;
      aw_lock_q <= 1'b0;
      ar_lock_q <= 1'b0;
    end else begin
      w_cnt     <= w_cnt_d;
      r_cnt     <= r_cnt_d;
      aw_lock_q <= aw_lock_d;
      ar_lock_q <= ar_lock_d;
    end
  end

  assign w_outstanding_o = w_cnt;
  assign r_outstanding_o = r_cnt;
  assign idle_o          = (w_cnt == '0) && (r_cnt == '0);

`ifndef SYNTHESIS
  a_no_spurious_b: assert property (@(posedge clk_i) disable iff (!rst_ni)
    b_hs |-> (w_cnt != '0)) else $fatal(1, "B handshake with no outstanding write");
  a_no_spurious_r: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_last_hs |-> (r_cnt != '0)) else $fatal(1, "R last with no outstanding read");
  a_w_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_cnt <= MaxCnt) else $fatal(1, "write count above MaxTxns");
  a_r_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_cnt <= MaxCnt) else $fatal(1, "read count above MaxTxns");
  a_aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    slv_req_i.aw_valid && !slv_resp_o.aw_ready |=> slv_req_i.aw_valid && $stable(slv_req_i.aw))
    else $fatal(1, "AW payload changed while stalled");
  a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    slv_req_i.ar_valid && !slv_resp_o.ar_ready |=> slv_req_i.ar_valid && $stable(slv_req_i.ar))
    else $fatal(1, "AR payload changed while stalled");
  a_w_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    slv_req_i.w_valid && !slv_resp_o.w_ready |=> slv_req_i.w_valid && $stable(slv_req_i.w))
    else $fatal(1, "W payload changed while stalled");
`endif

endmodule

// File: tb/tb_axi_txn_limiter.sv
// Self-checking bench for axi_txn_limiter: directed vector table, hand-written
// clamp/reset sequence, then random traffic against a transaction-level model.

module tb_axi_txn_limiter;
  import axi_txn_pkg::*;

  localparam int MaxTxns = 8;
  localparam int CntW    = $clog2(MaxTxns + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  axi_req_t        slv_req, mst_req;
  axi_rsp_t        slv_resp, mst_resp;
  logic [CntW-1:0] max_w, max_r, w_out, r_out;
  logic            idle;

  int n_vec  = 0;
  int n_miss = 0;

  axi_txn_limiter #(.MaxTxns(MaxTxns)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp),
    .max_w_txns_i(max_w), .max_r_txns_i(max_r),
    .w_outstanding_o(w_out), .r_outstanding_o(r_out), .idle_o(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit aw_v, atop, aw_rdy, ar_v, ar_rdy, b_v, r_v, r_last,
                       input int lw, lr);
    slv_req          = '0;
    mst_resp         = '0;
    slv_req.aw_valid = aw_v;
    slv_req.aw.atop  = {atop, 5'd0};
    slv_req.ar_valid = ar_v;
    slv_req.b_ready  = 1'b1;
    slv_req.r_ready  = 1'b1;
    mst_resp.aw_ready = aw_rdy;
    mst_resp.ar_ready = ar_rdy;
    mst_resp.b_valid  = b_v;
    mst_resp.r_valid  = r_v;
    mst_resp.r.last   = r_last;
    max_w = CntW'(lw);
    max_r = CntW'(lr);
  endtask

  typedef struct {
    bit aw_v, atop, aw_rdy, ar_v, ar_rdy, b_v, r_v, r_last;
    int lw, lr;
    bit e_maw, e_saw, e_mar, e_sar;
    int e_w, e_r;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit a, b, c, d, e, f, g, h, input int lw, lr,
                              input bit i, j, k, l, input int ew, er);
    vec_t v;
    v.aw_v = a; v.atop = b; v.aw_rdy = c; v.ar_v = d; v.ar_rdy = e;
    v.b_v = f; v.r_v = g; v.r_last = h; v.lw = lw; v.lr = lr;
    v.e_maw = i; v.e_saw = j; v.e_mar = k; v.e_sar = l; v.e_w = ew; v.e_r = er;
    return v;
  endfunction

  // Random-phase state: upstream pending requests and the transaction-level model.
  aw_chan_t aw_pl;
  ar_chan_t ar_pl;
  w_chan_t  w_pl;
  bit       aw_pend, ar_pend, w_pend;
  bit       aw_shown, ar_shown;     // presented downstream, not yet accepted
  int       w_n;                    // outstanding writes
  int       r_q[$];                 // outstanding reads: beats still to come
  axi_req_t exp_req;
  axi_rsp_t exp_rsp;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8, 8);
    #12;
    check("reset w_out", w_out, 0);
    check("reset r_out", r_out, 0);
    check("reset idle", idle, 1);
    @(negedge clk);
    rst_n = 1'b1;

    //            awv at awr arv arr bv rv rl  lw lr  maw saw mar sar  w  r
    // Lw=2: back-to-back AWs with B held off, then released.
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 2, 8, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 2, 8, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 2, 8, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 2, 8, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 2, 8, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 2, 8, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 2, 8, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 2, 8, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2, 8, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2, 8, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 8, 0, 0, 0, 0, 0, 0));
    // Lr=1 stalled AR, limit drops to 0: locked AR still completes.
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 8, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 8, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 8, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 8, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0, 1));
    // Lr=1 burst of 4 beats: only the last beat decrements.
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 8, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 8, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0));
    // Lr=3, r_cnt=2: ATOP AW wins the last read slot over a same-cycle AR.
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 8, 3, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 8, 3, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, 8, 3, 1, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 8, 3, 0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 8, 3, 0, 0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 8, 3, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 8, 3, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8, 3, 0, 0, 0, 0, 0, 0));
    // Lw=4: AW and B in the same cycle at Lw-1 net to zero.
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 4, 8, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 4, 8, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 4, 8, 1, 1, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 4, 8, 1, 1, 0, 0, 3, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 4, 8, 1, 1, 0, 0, 3, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 4, 8, 1, 1, 0, 0, 3, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 4, 8, 0, 0, 0, 0, 4, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 4, 8, 1, 1, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 4, 8, 0, 0, 0, 0, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 4, 8, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 4, 8, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 4, 8, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 8, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      next_cycle();
      drive(tbl[i].aw_v, tbl[i].atop, tbl[i].aw_rdy, tbl[i].ar_v, tbl[i].ar_rdy,
            tbl[i].b_v, tbl[i].r_v, tbl[i].r_last, tbl[i].lw, tbl[i].lr);
      #1;
      check($sformatf("v%0d mst aw_valid", i), mst_req.aw_valid, tbl[i].e_maw);
      check($sformatf("v%0d slv aw_ready", i), slv_resp.aw_ready, tbl[i].e_saw);
      check($sformatf("v%0d mst ar_valid", i), mst_req.ar_valid, tbl[i].e_mar);
      check($sformatf("v%0d slv ar_ready", i), slv_resp.ar_ready, tbl[i].e_sar);
      check($sformatf("v%0d w_out", i), w_out, tbl[i].e_w);
      check($sformatf("v%0d r_out", i), r_out, tbl[i].e_r);
      check($sformatf("v%0d idle", i), idle, int'(tbl[i].e_w == 0 && tbl[i].e_r == 0));
    end

    // Limit 15 clamps to 8; the 9th AW stalls. Then async reset mid-burst.
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      drive(1, 0, 1, 0, 0, 0, 0, 0, 15, 8);
      #1;
      check($sformatf("clamp aw%0d ready", i), slv_resp.aw_ready, 1);
      check($sformatf("clamp aw%0d w_out", i), w_out, i);
    end
    next_cycle();
    drive(1, 0, 1, 1, 0, 0, 0, 0, 15, 8);
    #1;
    check("clamp 9th mst aw_valid", mst_req.aw_valid, 0);
    check("clamp 9th slv aw_ready", slv_resp.aw_ready, 0);
    check("clamp w_out", w_out, 8);
    check("clamp ar shown", mst_req.ar_valid, 1);
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset w_out", w_out, 0);
    check("async reset r_out", r_out, 0);
    check("async reset idle", idle, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8, 8);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    drive(0, 0, 0, 1, 0, 0, 0, 0, 8, 0);
    #1;
    check("reset clears ar lock", mst_req.ar_valid, 0);
    next_cycle();
    drive(0, 0, 0, 1, 1, 0, 0, 0, 8, 1);
    #1;
    check("ar after reset", slv_resp.ar_ready, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 8, 1);
    #1;
    check("r_out after reset ar", r_out, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 8, 8);
    #1;
    check("idle before random", idle, 1);

    // Random traffic against the transaction-level model.
    aw_pend = 0; ar_pend = 0; w_pend = 0; aw_shown = 0; ar_shown = 0; w_n = 0;
    r_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int  lw_c, lr_c, r_n;
      bit  aw_ok, ar_ok, atop_r, aw_hs, ar_hs;
      next_cycle();
      if (cyc % 25 == 0) begin
        max_w = CntW'($urandom_range(0, 15));
        max_r = CntW'($urandom_range(0, 15));
      end
      if (!aw_pend && $urandom_range(0, 2) == 0) begin
        aw_pend      = 1;
        aw_pl.id     = 4'($urandom);
        aw_pl.addr   = $urandom;
        aw_pl.len    = 8'($urandom_range(0, 7));
        aw_pl.atop   = 6'($urandom);
        aw_pl.atop[5] = ($urandom_range(0, 9) < 3);
      end
      if (!ar_pend && $urandom_range(0, 2) == 0) begin
        ar_pend    = 1;
        ar_pl.id   = 4'($urandom);
        ar_pl.addr = $urandom;
        ar_pl.len  = 8'($urandom_range(0, 3));
      end
      if (!w_pend && $urandom_range(0, 1) == 0) begin
        w_pend     = 1;
        w_pl.data  = $urandom;
        w_pl.strb  = 4'($urandom);
        w_pl.last  = 1'($urandom);
      end
      slv_req.aw_valid = aw_pend;  slv_req.aw = aw_pl;
      slv_req.ar_valid = ar_pend;  slv_req.ar = ar_pl;
      slv_req.w_valid  = w_pend;   slv_req.w  = w_pl;
      slv_req.b_ready  = ($urandom_range(0, 3) != 0);
      slv_req.r_ready  = ($urandom_range(0, 3) != 0);
      mst_resp.aw_ready = ($urandom_range(0, 2) != 0);
      mst_resp.ar_ready = ($urandom_range(0, 2) != 0);
      mst_resp.w_ready  = 1'($urandom);
      mst_resp.b_valid  = (w_n > 0) && ($urandom_range(0, 2) != 0);
      mst_resp.b        = b_chan_t'($urandom);
      mst_resp.r_valid  = (r_q.size() > 0) && ($urandom_range(0, 2) != 0);
      mst_resp.r.id     = 4'($urandom);
      mst_resp.r.data   = $urandom;
      mst_resp.r.resp   = 2'($urandom);
      mst_resp.r.last   = (r_q.size() > 0) && (r_q[0] == 1);
      #1;

      lw_c   = (int'(max_w) > MaxTxns) ? MaxTxns : int'(max_w);
      lr_c   = (int'(max_r) > MaxTxns) ? MaxTxns : int'(max_r);
      r_n    = r_q.size();
      atop_r = aw_pl.atop[5];
      aw_ok  = aw_shown || (w_n < lw_c && (!atop_r || r_n + int'(ar_shown) < lr_c));
      ar_ok  = ar_shown || (r_n + int'(aw_pend && aw_ok && atop_r) < lr_c);

      check($sformatf("rnd%0d mst aw_valid", cyc), mst_req.aw_valid, int'(aw_pend && aw_ok));
      check($sformatf("rnd%0d slv aw_ready", cyc), slv_resp.aw_ready,
            int'(mst_resp.aw_ready && aw_ok));
      check($sformatf("rnd%0d mst ar_valid", cyc), mst_req.ar_valid, int'(ar_pend && ar_ok));
      check($sformatf("rnd%0d slv ar_ready", cyc), slv_resp.ar_ready,
            int'(mst_resp.ar_ready && ar_ok));
      check($sformatf("rnd%0d w_out", cyc), w_out, w_n);
      check($sformatf("rnd%0d r_out", cyc), r_out, r_n);
      check($sformatf("rnd%0d idle", cyc), idle, int'(w_n == 0 && r_n == 0));
      exp_req          = slv_req;
      exp_req.aw_valid = aw_pend && aw_ok;
      exp_req.ar_valid = ar_pend && ar_ok;
      exp_rsp          = mst_resp;
      exp_rsp.aw_ready = mst_resp.aw_ready && aw_ok;
      exp_rsp.ar_ready = mst_resp.ar_ready && ar_ok;
      check($sformatf("rnd%0d req passthrough", cyc), int'(mst_req == exp_req), 1);
      check($sformatf("rnd%0d rsp passthrough", cyc), int'(slv_resp == exp_rsp), 1);

      // Retire responses against transactions outstanding before this cycle.
      if (mst_resp.b_valid && slv_req.b_ready) w_n--;
      if (mst_resp.r_valid && slv_req.r_ready) begin
        if (r_q[0] == 1) void'(r_q.pop_front());
        else r_q[0] = r_q[0] - 1;
      end
      aw_hs = aw_pend && aw_ok && mst_resp.aw_ready;
      ar_hs = ar_pend && ar_ok && mst_resp.ar_ready;
      if (aw_hs) begin
        w_n++;
        if (atop_r) r_q.push_back(1);
        aw_pend  = 0;
        aw_shown = 0;
      end else if (aw_pend && aw_ok) begin
        aw_shown = 1;
      end
      if (ar_hs) begin
        r_q.push_back(int'(ar_pl.len) + 1);
        ar_pend  = 0;
        ar_shown = 0;
      end else if (ar_pend && ar_ok) begin
        ar_shown = 1;
      end
      if (w_pend && mst_resp.w_ready) w_pend = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
